// File: rtl/distance_alarm_ctrl.sv
// distance_alarm_ctrl: periodically samples the ultrasonic distance result,
// classifies it into FAR/NEAR/CLOSE/DANGER zones with hysteresis and
// N-sample confirmation, and drives a parking-sensor buzzer, a one-hot zone
// LED bar and a one-cycle zone-change strobe.
module distance_alarm_ctrl #(
   parameter int CLK_FREQ_MHZ    = 100,
   parameter int SAMPLE_MS       = 10,
   parameter int NEAR_CM         = 50,
   parameter int CLOSE_CM        = 25,
   parameter int DANGER_CM       = 10,
   parameter int HYST_CM         = 2,
   parameter int CONFIRM         = 3,
   parameter int BEEP_ON_MS      = 50,
   parameter int NEAR_PERIOD_MS  = 800,
   parameter int CLOSE_PERIOD_MS = 300
) (
   input  logic        clk,
   input  logic        reset_p,
   input  logic [15:0] distance_cm,
   input  logic        enable,
   output logic        buzz,
   output logic [1:0]  zone,
   output logic [3:0]  led,
   output logic        zone_change
);

   // Counter widths; single-state counters still get one bit
   localparam int US_W  = (CLK_FREQ_MHZ > 1) ? $clog2(CLK_FREQ_MHZ) : 1;
   localparam int SMP_W = (SAMPLE_MS > 1) ? $clog2(SAMPLE_MS) : 1;
   localparam int CNT_W = $clog2(CONFIRM + 1);

   localparam logic [US_W-1:0]  US_MAX    = US_W'(CLK_FREQ_MHZ - 1);
   localparam logic [9:0]       MS_MAX    = 10'd999;
   localparam logic [SMP_W-1:0] SMP_MAX   = SMP_W'(SAMPLE_MS - 1);
   localparam logic [CNT_W-1:0] CONFIRM_C = CNT_W'(CONFIRM);

   // Entry thresholds (moving closer) and exit thresholds (moving farther)
   localparam logic [15:0] NEAR_IN    = 16'(NEAR_CM);
   localparam logic [15:0] CLOSE_IN   = 16'(CLOSE_CM);
   localparam logic [15:0] DANGER_IN  = 16'(DANGER_CM);
   localparam logic [15:0] NEAR_OUT   = 16'(NEAR_CM + HYST_CM);
   localparam logic [15:0] CLOSE_OUT  = 16'(CLOSE_CM + HYST_CM);
   localparam logic [15:0] DANGER_OUT = 16'(DANGER_CM + HYST_CM);

   localparam logic [15:0] BEEP_ON_C  = 16'(BEEP_ON_MS);
   localparam logic [15:0] NEAR_LAST  = 16'(NEAR_PERIOD_MS - 1);
   localparam logic [15:0] CLOSE_LAST = 16'(CLOSE_PERIOD_MS - 1);

   typedef enum logic [1:0] {
      ZONE_FAR    = 2'd0,
      ZONE_NEAR   = 2'd1,
      ZONE_CLOSE  = 2'd2,
      ZONE_DANGER = 2'd3
   } zone_e;

   // Map a distance onto a zone using the given threshold set
   function automatic logic [1:0] classify(input logic [15:0] d,
                                           input logic [15:0] t_near,
                                           input logic [15:0] t_close,
                                           input logic [15:0] t_danger);
      logic [1:0] z;
      if (d < t_danger) begin
         z = ZONE_DANGER;
      end else if (d < t_close) begin
         z = ZONE_CLOSE;
      end else if (d < t_near) begin
         z = ZONE_NEAR;
      end else begin
         z = ZONE_FAR;
      end
      return z;
   endfunction

   // One-hot LED pattern for a zone
   function automatic logic [3:0] zone_led(input logic [1:0] z);
      logic [3:0] l;
      case (z)
         2'd0:    l = 4'b0001;
         2'd1:    l = 4'b0010;
         2'd2:    l = 4'b0100;
         2'd3:    l = 4'b1000;
         default: l = 4'b0001;
      endcase
      return l;
   endfunction

   logic [US_W-1:0]  us_cnt_r;
   logic [9:0]       ms_cnt_r;
   logic [SMP_W-1:0] smp_cnt_r;
   logic             us_tick_s;
   logic             ms_tick_s;
   logic             sample_s;

   logic [1:0]       zone_r;
   logic [3:0]       led_r;
   logic             zone_change_r;
   logic [1:0]       pend_r;
   logic [CNT_W-1:0] cnt_r;
   logic [15:0]      phase_r;
   logic             buzz_r;

   logic [1:0]       z_in_s;
   logic [1:0]       z_out_s;
   logic [1:0]       cand_s;
   logic [CNT_W-1:0] next_cnt_s;
   logic             valid_smp_s;
   logic             commit_s;
   logic [15:0]      phase_last_s;
   logic             beeping_s;
   logic             buzz_s;

   assign us_tick_s = (us_cnt_r == US_MAX);
   assign ms_tick_s = us_tick_s && (ms_cnt_r == MS_MAX);
   assign sample_s  = ms_tick_s && (smp_cnt_r == SMP_MAX);

   // Free-running us / ms / sample divider chain, independent of enable
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         us_cnt_r  <= '0;
         ms_cnt_r  <= '0;
         smp_cnt_r <= '0;
      end else begin
         if (us_tick_s) begin
            us_cnt_r <= '0;
         end else begin
            us_cnt_r <= us_cnt_r + US_W'(1);
         end
         if (ms_tick_s) begin
            ms_cnt_r <= '0;
         end else if (us_tick_s) begin
            ms_cnt_r <= ms_cnt_r + 10'd1;
         end
         if (sample_s) begin
            smp_cnt_r <= '0;
         end else if (ms_tick_s) begin
            smp_cnt_r <= smp_cnt_r + SMP_W'(1);
         end
      end
   end

   // Candidate zone with hysteresis and confirmation bookkeeping
   always_comb begin
      z_in_s  = classify(distance_cm, NEAR_IN, CLOSE_IN, DANGER_IN);
      z_out_s = classify(distance_cm, NEAR_OUT, CLOSE_OUT, DANGER_OUT);
      if (z_in_s > zone_r) begin
         cand_s = z_in_s;
      end else if (z_out_s < zone_r) begin
         cand_s = z_out_s;
      end else begin
         cand_s = zone_r;
      end
      if (cand_s == pend_r) begin
         next_cnt_s = cnt_r + CNT_W'(1);
      end else begin
         next_cnt_s = CNT_W'(1);
      end
      valid_smp_s = sample_s && enable && (distance_cm != 16'd0);
      if (valid_smp_s && (cand_s != zone_r) && (next_cnt_s == CONFIRM_C)) begin
         commit_s = 1'b1;
      end else begin
         commit_s = 1'b0;
      end
   end

   // Zone register, LED bar, change strobe and confirmation state
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         zone_r        <= ZONE_FAR;
         led_r         <= 4'b0001;
         zone_change_r <= 1'b0;
         pend_r        <= 2'd0;
         cnt_r         <= '0;
      end else if (!enable) begin
         zone_r        <= ZONE_FAR;
         led_r         <= 4'b0001;
         zone_change_r <= 1'b0;
         pend_r        <= 2'd0;
         cnt_r         <= '0;
      end else begin
         zone_change_r <= 1'b0;
         if (valid_smp_s) begin
            if (cand_s == zone_r) begin
               cnt_r <= '0;
            end else if (commit_s) begin
               zone_r        <= cand_s;
               led_r         <= zone_led(cand_s);
               zone_change_r <= 1'b1;
               pend_r        <= cand_s;
               cnt_r         <= '0;
            end else begin
               pend_r <= cand_s;
               cnt_r  <= next_cnt_s;
            end
         end
      end
   end

   // Beep period end and buzzer level for the current zone and phase
   always_comb begin
      case (zone_r)
         ZONE_FAR: begin
            phase_last_s = 16'd0;
            beeping_s    = 1'b0;
            buzz_s       = 1'b0;
         end
         ZONE_NEAR: begin
            phase_last_s = NEAR_LAST;
            beeping_s    = 1'b1;
            buzz_s       = (phase_r < BEEP_ON_C);
         end
         ZONE_CLOSE: begin
            phase_last_s = CLOSE_LAST;
            beeping_s    = 1'b1;
            buzz_s       = (phase_r < BEEP_ON_C);
         end
         ZONE_DANGER: begin
            phase_last_s = 16'd0;
            beeping_s    = 1'b0;
            buzz_s       = 1'b1;
         end
         default: begin
            phase_last_s = 16'd0;
            beeping_s    = 1'b0;
            buzz_s       = 1'b0;
         end
      endcase
   end

   // Beep phase counter (restarted on every zone change) and buzzer register
   always_ff @(posedge clk or posedge reset_p) begin
      if (reset_p) begin
         phase_r <= 16'd0;
         buzz_r  <= 1'b0;
      end else if (!enable) begin
         phase_r <= 16'd0;
         buzz_r  <= 1'b0;
      end else begin
         if (commit_s) begin
            phase_r <= 16'd0;
         end else if (ms_tick_s) begin
            if (!beeping_s || (phase_r >= phase_last_s)) begin
               phase_r <= 16'd0;
            end else begin
               phase_r <= phase_r + 16'd1;
            end
         end
         buzz_r <= buzz_s;
      end
   end

   assign buzz        = buzz_r;
   assign zone        = zone_r;
   assign led         = led_r;
   assign zone_change = zone_change_r;

endmodule

// File: doc/distance_alarm_ctrl.md
Name: distance_alarm_ctrl

Overview:
Downstream consumer of the ultrasonic ranging stage. Samples its 16-bit distance_cm result periodically and classifies the distance into four proximity zones, using hysteresis and N-sample confirmation. Drives a parking-sensor style buzzer pattern (silent, slow beep, fast beep, continuous), a one-hot zone LED bar and a zone-change strobe for the top level.

Parameters:
CLK_FREQ_MHZ, 100, system clock in MHz; sets the 1 us tick divider
SAMPLE_MS, 10, interval between distance samples, in ms
NEAR_CM, 50, distance below which the zone is NEAR or closer
CLOSE_CM, 25, distance below which the zone is CLOSE or closer
DANGER_CM, 10, distance below which the zone is DANGER
HYST_CM, 2, extra margin required to move to a farther zone
CONFIRM, 3, consecutive agreeing samples required before a zone change (>=1)
BEEP_ON_MS, 50, buzzer on-time per beep period
NEAR_PERIOD_MS, 800, beep period in NEAR
CLOSE_PERIOD_MS, 300, beep period in CLOSE

Ports:
clk  input  1  system clock; all logic on posedge
reset_p  input  1  asynchronous, active-high reset
distance_cm  input  16  distance from the ultrasonic stage; 0 means no valid measurement
enable  input  1  alarm enable
buzz  output  1  buzzer drive, registered
zone  output  2  current zone: 0 FAR, 1 NEAR, 2 CLOSE, 3 DANGER
led  output  4  one-hot zone indicator: led[zone]=1
zone_change  output  1  one-cycle pulse when zone updates

Behaviour:
- Interface: one clock, clk. Reset reset_p is asynchronous and active-high.
- Reset values: buzz=0, zone=0, led=4'b0001, zone_change=0. All counters, pending candidate and confirm count are cleared.
- Tick chain:
  - us counter wraps at CLK_FREQ_MHZ-1 and produces a 1-cycle us tick.
  - ms counter wraps at 999 us ticks and produces a 1-cycle ms tick.
  - sample counter wraps at SAMPLE_MS-1 ms ticks and produces a 1-cycle sample strobe.
- Sample: on each sample strobe, d = distance_cm is captured. If d==0, the sample is ignored: no change to pending or count.
- Classification, with thresholds compared as strict less-than on unsigned 16-bit values:
  - z_in: 3 if d<DANGER_CM, 2 if d<CLOSE_CM, 1 if d<NEAR_CM, else 0.
  - z_out: same rule with every threshold increased by HYST_CM.
  - candidate = z_in if z_in>zone; else z_out if z_out<zone; else zone.
  - Zones may jump more than one step, e.g. FAR->DANGER.
- Confirmation, evaluated per valid sample:
  - candidate==zone: count cleared.
  - candidate==pending: count+1.
  - Otherwise: pending<=candidate, count<=1.
  - When count would reach CONFIRM: zone<=pending, zone_change=1 for exactly that cycle, count cleared, beep phase cleared.
  - With CONFIRM=1, a single sample changes the zone.
- Buzzer:
  - Phase counter counts ms ticks from 0 to period-1 and wraps.
  - FAR: buzz=0.
  - NEAR: buzz = phase<BEEP_ON_MS, with period NEAR_PERIOD_MS.
  - CLOSE: same rule with period CLOSE_PERIOD_MS.
  - DANGER: buzz=1.
  - buzz is registered and reflects a new zone one cycle after the zone update; a new beep starts immediately on entering NEAR or CLOSE.
- led: registered one-hot decode of zone, updated in the same cycle as zone.
- enable=0:
  - Sampling halts; zone forced to 0 and led to 4'b0001.
  - buzz=0; pending, count and phase are cleared.
  - No zone_change pulse is generated by the forced return.
  - The tick chain keeps running.
- enable rising: fresh confirmation from FAR; the first zone change needs CONFIRM samples.
- Reset mid-beep or mid-confirmation: all outputs return to reset values immediately (asynchronous).
- Simultaneous sample strobe and ms tick: both are processed. If a zone change occurs in that cycle, the clearing of phase wins over the phase increment.

Test Plan:
- Bench parameters: CLK_FREQ_MHZ=2, SAMPLE_MS=1, CONFIRM=3, defaults otherwise.
- Reset then hold distance_cm=100 -> zone=0, led=0001, buzz=0 throughout; no zone_change pulse.
- Step distance_cm 100->40 -> zone=1 after the 3rd sample (~3 ms); one zone_change pulse. buzz high 50 ms, low 750 ms, repeating with an 800 ms period.
- Step distance_cm 100->5 -> zone jumps 0->3 after 3 samples; buzz stays continuously 1; led=1000.
- Hysteresis from zone=1 (NEAR): distance_cm=50 or 51 -> zone stays 1. distance_cm=52 held for 3 samples -> zone=0, buzz=0.
- Flicker sequence 40,100,40,40,100 -> zone never leaves 0; the confirm count restarts on each disagreement.
- distance_cm=0 interleaved (40,0,40,0,40) -> zone=1 after the 3rd nonzero sample. Then drop enable in DANGER -> buzz=0, zone=0 next cycle, no zone_change pulse. Assert reset_p mid-beep -> buzz=0 asynchronously.
